// File: rtl/subleq_sequencer_if.sv
// Shared memory port between the SUBLEQ sequencer (master) and the memory (slave).
// One req/ack transaction at a time; read data is valid in the ack cycle.
interface subleq_sequencer_if #(
    parameter int WORD_SIZE = 16
);
    logic                 mem_req;
    logic                 mem_we;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic                 mem_ack;
    logic [WORD_SIZE-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/subleq_sequencer.sv
// Control FSM for the single-instruction SUBLEQ core: fetch A/B/C, load operands,
// write mem[B]-mem[A] back and branch on a non-positive result.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start after reset
// FETCH_A  | reading instruction word A at pc
// FETCH_B  | reading instruction word B at pc+1
// FETCH_C  | reading instruction word C at pc+2
// LOAD_A   | reading operand mem[A]
// LOAD_B   | reading operand mem[B], computing the result
// WRITE    | writing the result to mem[B], then choosing the next pc
// HALT     | stopped on a taken branch to HALT_ADDR; start restarts
module subleq_sequencer #(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] HALT_ADDR = {WORD_SIZE{1'b1}}
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] start_pc,
    subleq_sequencer_if.master   mem,
    output logic [WORD_SIZE-1:0] pc,
    output logic                 busy,
    output logic                 halted,
    output logic [31:0]          instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_A,
        S_FETCH_B,
        S_FETCH_C,
        S_LOAD_A,
        S_LOAD_B,
        S_WRITE,
        S_HALT
    } state_t;

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] a_q, a_d;
    logic [WORD_SIZE-1:0] b_q, b_d;
    logic [WORD_SIZE-1:0] c_q, c_d;
    logic [WORD_SIZE-1:0] opa_q, opa_d;
    logic                 busy_q, busy_d;
    logic                 halted_q, halted_d;
    logic [31:0]          instr_count_q, instr_count_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;

    logic                 xfer_done;
    logic                 res_le_zero;
    logic [WORD_SIZE-1:0] pc_plus1;
    logic [WORD_SIZE-1:0] pc_plus2;
    logic [WORD_SIZE-1:0] pc_plus3;

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            c_q           <= '0;
            opa_q         <= '0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
            instr_count_q <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            a_q           <= a_d;
            b_q           <= b_d;
            c_q           <= c_d;
            opa_q         <= opa_d;
            busy_q        <= busy_d;
            halted_q      <= halted_d;
            instr_count_q <= instr_count_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    // The result lives in the write-data register from LOAD_B until the write completes.
    assign xfer_done   = mem_req_q && mem.mem_ack;
    assign res_le_zero = (mem_wdata_q == '0) || mem_wdata_q[WORD_SIZE-1];
    assign pc_plus1    = pc_q + WORD_SIZE'(1);
    assign pc_plus2    = pc_q + WORD_SIZE'(2);
    assign pc_plus3    = pc_q + WORD_SIZE'(3);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        a_d           = a_q;
        b_d           = b_q;
        c_d           = c_q;
        opa_d         = opa_q;
        busy_d        = busy_q;
        halted_d      = halted_q;
        instr_count_d = instr_count_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d       = S_FETCH_A;
                    pc_d          = start_pc;
                    busy_d        = 1'b1;
                    halted_d      = 1'b0;
                    instr_count_d = '0;
                    mem_req_d     = 1'b1;
                    mem_we_d      = 1'b0;
                    mem_addr_d    = start_pc;
                end
            end
            S_FETCH_A: begin
                if (xfer_done) begin
                    a_d        = mem.mem_rdata;
                    mem_addr_d = pc_plus1;
                    state_d    = S_FETCH_B;
                end
            end
            S_FETCH_B: begin
                if (xfer_done) begin
                    b_d        = mem.mem_rdata;
                    mem_addr_d = pc_plus2;
                    state_d    = S_FETCH_C;
                end
            end
            S_FETCH_C: begin
                if (xfer_done) begin
                    c_d        = mem.mem_rdata;
                    mem_addr_d = a_q;
                    state_d    = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                if (xfer_done) begin
                    opa_d      = mem.mem_rdata;
                    mem_addr_d = b_q;
                    state_d    = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                if (xfer_done) begin
                    mem_wdata_d = mem.mem_rdata - opa_q;
                    mem_we_d    = 1'b1;
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                if (xfer_done) begin
                    instr_count_d = instr_count_q + 32'd1;
                    mem_we_d      = 1'b0;
                    if (res_le_zero && (c_q == HALT_ADDR)) begin
                        state_d   = S_HALT;
                        busy_d    = 1'b0;
                        halted_d  = 1'b1;
                        mem_req_d = 1'b0;
                    end else begin
                        // Only a taken branch can halt; a fall-through onto HALT_ADDR just runs.
                        pc_d       = res_le_zero ? c_q : pc_plus3;
                        mem_addr_d = res_le_zero ? c_q : pc_plus3;
                        state_d    = S_FETCH_A;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign pc            = pc_q;
    assign busy          = busy_q;
    assign halted        = halted_q;
    assign instr_count   = instr_count_q;

endmodule

// File: tb/tb_subleq_sequencer.sv
// Bench for subleq_sequencer: wait-stated memory model, instruction-level reference
// model, single-instruction vector table and randomized programs.
module tb_subleq_sequencer;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          areset = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  start_pc = '0;
    logic [W-1:0]  pc;
    logic          busy;
    logic          halted;
    logic [31:0]   instr_count;

    subleq_sequencer_if #(.WORD_SIZE(W)) bus ();

    subleq_sequencer #(.WORD_SIZE(W)) dut (
        .clk         (clk),
        .areset      (areset),
        .start       (start),
        .start_pc    (start_pc),
        .mem         (bus),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         we;
        logic [W-1:0] addr;
        logic [W-1:0] data;
    } xact_t;

    typedef struct {
        logic [W-1:0] spc;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] exp_res;
        logic [W-1:0] exp_pc;
        logic         exp_halt;
    } vec_t;

    xact_t        log_q[$];
    xact_t        exp_q[$];
    logic [W-1:0] mem     [0:65535];
    logic [W-1:0] ref_mem [0:65535];

    int unsigned  wait_cnt = 0;
    int unsigned  max_wait = 0;
    bit           noise_en = 0;
    bit           noise_bit = 0;
    bit           force_ack = 0;
    bit           hold_ack = 0;
    int           total = 0;
    int           bad = 0;
    int           req_cycles = 0;
    bit           pend = 0;
    logic         pend_we = 1'b0;
    logic [W-1:0] pend_addr = '0;
    logic [W-1:0] pend_wdata = '0;

    logic [W-1:0] m_pc;
    int           m_cnt;
    bit           m_halt;

    assign bus.mem_ack   = force_ack
                         | (!hold_ack & bus.mem_req & (wait_cnt == 0))
                         | (noise_en & !bus.mem_req & noise_bit);
    assign bus.mem_rdata = mem[bus.mem_addr];

    // Memory model: completes on req&&ack, logs every transaction, checks request stability.
    always @(posedge clk) begin
        noise_bit <= 1'($urandom_range(1, 0));
        if (bus.mem_req) req_cycles++;
        if (!areset && pend && bus.mem_req) begin
            total++;
            if (bus.mem_addr !== pend_addr || bus.mem_we !== pend_we ||
                (pend_we && bus.mem_wdata !== pend_wdata)) begin
                bad++;
                $display("FAIL hold_stable: got we=%0b addr=%0h wdata=%0h expected we=%0b addr=%0h wdata=%0h",
                         bus.mem_we, bus.mem_addr, bus.mem_wdata, pend_we, pend_addr, pend_wdata);
            end
        end
        pend       = !areset && bus.mem_req && !bus.mem_ack;
        pend_we    = bus.mem_we;
        pend_addr  = bus.mem_addr;
        pend_wdata = bus.mem_wdata;
        if (!areset && bus.mem_req && bus.mem_ack) begin
            log_q.push_back(mk(bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : bus.mem_rdata));
            if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
            wait_cnt <= $urandom_range(max_wait, 0);
        end else if (bus.mem_req && wait_cnt != 0 && !hold_ack) begin
            wait_cnt <= wait_cnt - 1;
        end
    end

    function automatic xact_t mk(input logic we, input logic [W-1:0] addr, input logic [W-1:0] data);
        xact_t x;
        x.we   = we;
        x.addr = addr;
        x.data = data;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
    endtask

    task automatic put(input logic [W-1:0] addr, input logic [W-1:0] val);
        mem[addr]     = val;
        ref_mem[addr] = val;
    endtask

    task automatic do_reset();
        @(negedge clk);
        areset = 1'b1;
        start  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        areset = 1'b0;
    endtask

    task automatic pulse_start(input logic [W-1:0] spc);
        @(negedge clk);
        start    = 1'b1;
        start_pc = spc;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_run(input int target, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (halted || instr_count >= 32'(target)) begin
                ok = 1;
                break;
            end
        end
    endtask

    // Instruction-level SUBLEQ reference: each instruction is six memory transactions.
    task automatic model_run(input logic [W-1:0] spc, input int max_i);
        logic [W-1:0] a, b, c, va, vb, res, p1, p2;
        exp_q.delete();
        m_pc   = spc;
        m_cnt  = 0;
        m_halt = 0;
        while (m_cnt < max_i && !m_halt) begin
            p1  = m_pc + 16'd1;
            p2  = m_pc + 16'd2;
            a   = ref_mem[m_pc];
            b   = ref_mem[p1];
            c   = ref_mem[p2];
            va  = ref_mem[a];
            vb  = ref_mem[b];
            res = vb - va;
            exp_q.push_back(mk(1'b0, m_pc, a));
            exp_q.push_back(mk(1'b0, p1, b));
            exp_q.push_back(mk(1'b0, p2, c));
            exp_q.push_back(mk(1'b0, a, va));
            exp_q.push_back(mk(1'b0, b, vb));
            exp_q.push_back(mk(1'b1, b, res));
            ref_mem[b] = res;
            m_cnt++;
            if ($signed(res) <= 0) begin
                if (c == 16'hFFFF) m_halt = 1;
                else               m_pc = c;
            end else begin
                m_pc = m_pc + 16'd3;
            end
        end
    endtask

    task automatic compare_trace(input string name, input int n);
        int mism;
        int first;
        mism  = 0;
        first = -1;
        chk({name, "_len"}, 32'(log_q.size() >= n), 32'd1);
        for (int i = 0; i < n && i < log_q.size() && i < exp_q.size(); i++) begin
            if (log_q[i] !== exp_q[i]) begin
                mism++;
                if (first < 0) first = i;
            end
        end
        if (first >= 0)
            $display("  %s first differing transaction %0d: got %h want %h", name, first, log_q[first], exp_q[first]);
        chk({name, "_diffs"}, 32'(mism), 32'd0);
    endtask

    task automatic load_prog1();
        put(16'd0, 16'd9);  put(16'd1, 16'd10); put(16'd2, 16'd3);
        put(16'd3, 16'd10); put(16'd4, 16'd10); put(16'd5, 16'hFFFF);
        put(16'd9, 16'd5);  put(16'd10, 16'd7);
    endtask

    task automatic load_wrap_prog();
        put(16'hFFFE, 16'd100); put(16'hFFFF, 16'd101); put(16'h0000, 16'h0050);
        put(16'd100, 16'd1);    put(16'd101, 16'd5);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [9];
        bit   ok;
        logic [W-1:0] t;

        vecs[0] = '{16'h0100, 16'h0200, 16'h0201, 16'h0300, 16'd5, 16'd7,     16'd2,     16'h0103, 1'b0};
        vecs[1] = '{16'h0100, 16'h0200, 16'h0200, 16'h0300, 16'd9, 16'd9,     16'd0,     16'h0300, 1'b0};
        vecs[2] = '{16'h0000, 16'd20,   16'd21,   16'h0040, 16'd1, 16'd0,     16'hFFFF,  16'h0040, 1'b0};
        vecs[3] = '{16'h0100, 16'h0200, 16'h0201, 16'hFFFF, 16'd3, 16'd3,     16'd0,     16'h0100, 1'b1};
        vecs[4] = '{16'h0180, 16'h0200, 16'h0201, 16'hFFFF, 16'd4, 16'd3,     16'hFFFF,  16'h0180, 1'b1};
        vecs[5] = '{16'hFFFC, 16'h0200, 16'h0201, 16'h0010, 16'd1, 16'd2,     16'd1,     16'hFFFF, 1'b0};
        vecs[6] = '{16'hFFFE, 16'd100,  16'd101,  16'h0050, 16'd1, 16'd5,     16'd4,     16'h0001, 1'b0};
        vecs[7] = '{16'h0400, 16'h0200, 16'h0201, 16'h0500, 16'd0, 16'h8000,  16'h8000,  16'h0500, 1'b0};
        vecs[8] = '{16'h0400, 16'h0200, 16'h0201, 16'h0500, 16'd0, 16'h7FFF,  16'h7FFF,  16'h0403, 1'b0};

        // Reset state
        do_reset();
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_count", instr_count, 32'd0);

        // Zero-wait two-instruction program ending in halt
        clear_mem();
        load_prog1();
        model_run(16'd0, 100);
        max_wait = 0;
        noise_en = 0;
        log_q.delete();
        req_cycles = 0;
        pulse_start(16'd0);
        wait_run(1000, 200, ok);
        chk("p1_done", 32'(ok), 32'd1);
        chk("p1_halted", 32'(halted), 32'd1);
        chk("p1_busy", 32'(busy), 32'd0);
        chk("p1_pc", 32'(pc), 32'd3);
        chk("p1_count", instr_count, 32'd2);
        chk("p1_nxact", 32'(log_q.size()), 32'd12);
        chk("p1_req_cycles", 32'(req_cycles), 32'd12);
        if (log_q.size() >= 12) begin
            chk("p1_w1_addr", 32'(log_q[5].addr), 32'd10);
            chk("p1_w1_data", 32'(log_q[5].data), 32'd2);
            chk("p1_w2_data", 32'(log_q[11].data), 32'd0);
        end
        compare_trace("p1_trace", 12);

        // Same program with random wait states, ack noise, and a start pulse while busy
        do_reset();
        clear_mem();
        load_prog1();
        model_run(16'd0, 100);
        max_wait = 3;
        noise_en = 1;
        log_q.delete();
        pulse_start(16'd0);
        for (int i = 0; i < 100 && log_q.size() < 3; i++) @(negedge clk);
        pulse_start(16'h1234);
        chk("busy_start_pc", 32'(pc), 32'd0);
        chk("busy_start_count", instr_count, 32'd0);
        chk("busy_start_busy", 32'(busy), 32'd1);
        wait_run(1000, 400, ok);
        chk("p2_done", 32'(ok), 32'd1);
        chk("p2_halted", 32'(halted), 32'd1);
        chk("p2_pc", 32'(pc), 32'd3);
        chk("p2_count", instr_count, 32'd2);
        repeat (4) @(negedge clk);
        chk("p2_nxact", 32'(log_q.size()), 32'd12);
        compare_trace("p2_trace", 12);

        // Restart from HALT at a wrapping start_pc
        clear_mem();
        load_wrap_prog();
        model_run(16'hFFFE, 1);
        log_q.delete();
        pulse_start(16'hFFFE);
        chk("restart_count", instr_count, 32'd0);
        chk("restart_pc", 32'(pc), 32'hFFFE);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_halted", 32'(halted), 32'd0);
        wait_run(1, 200, ok);
        chk("wrap_done", 32'(ok), 32'd1);
        chk("wrap_pc", 32'(pc), 32'h0001);
        if (log_q.size() >= 3) chk("wrap_fetch_c_addr", 32'(log_q[2].addr), 32'h0000);
        compare_trace("wrap_trace", 6);

        // Reset while the operand B read is outstanding
        do_reset();
        noise_en = 0;
        max_wait = 0;
        clear_mem();
        load_prog1();
        log_q.delete();
        pulse_start(16'd0);
        for (int i = 0; i < 50; i++) begin
            if (log_q.size() >= 4) begin
                hold_ack = 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        chk("lb_req", 32'(bus.mem_req), 32'd1);
        chk("lb_addr", 32'(bus.mem_addr), 32'd10);
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        hold_ack = 0;
        chk("mid_rst_req", 32'(bus.mem_req), 32'd0);
        chk("mid_rst_pc", 32'(pc), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
        force_ack = 1;
        repeat (3) @(negedge clk);
        force_ack = 0;
        chk("late_ack_req", 32'(bus.mem_req), 32'd0);
        chk("late_ack_busy", 32'(busy), 32'd0);
        chk("late_ack_pc", 32'(pc), 32'd0);
        chk("late_ack_nxact", 32'(log_q.size()), 32'd4);
        pulse_start(16'd0);
        chk("after_rst_start_busy", 32'(busy), 32'd1);

        // Single-instruction vector table
        for (int v = 0; v < 9; v++) begin
            do_reset();
            clear_mem();
            put(vecs[v].spc, vecs[v].a);
            t = vecs[v].spc + 16'd1;
            put(t, vecs[v].b);
            t = vecs[v].spc + 16'd2;
            put(t, vecs[v].c);
            put(vecs[v].a, vecs[v].va);
            put(vecs[v].b, vecs[v].vb);
            max_wait = 32'(v % 3);
            log_q.delete();
            pulse_start(vecs[v].spc);
            wait_run(1, 100, ok);
            chk($sformatf("v%0d_done", v), 32'(ok), 32'd1);
            chk($sformatf("v%0d_pc", v), 32'(pc), 32'(vecs[v].exp_pc));
            chk($sformatf("v%0d_halted", v), 32'(halted), 32'(vecs[v].exp_halt));
            chk($sformatf("v%0d_count", v), instr_count, 32'd1);
            chk($sformatf("v%0d_nxact", v), 32'(log_q.size() >= 6), 32'd1);
            if (log_q.size() >= 6) begin
                t = vecs[v].spc + 16'd2;
                chk($sformatf("v%0d_fetch_c_addr", v), 32'(log_q[2].addr), 32'(t));
                chk($sformatf("v%0d_wr_we", v), 32'(log_q[5].we), 32'd1);
                chk($sformatf("v%0d_wr_addr", v), 32'(log_q[5].addr), 32'(vecs[v].b));
                chk($sformatf("v%0d_wr_data", v), 32'(log_q[5].data), 32'(vecs[v].exp_res));
            end
        end

        // Randomized programs against the reference model
        for (int r = 0; r < 8; r++) begin
            do_reset();
            clear_mem();
            for (int i = 0; i < 64; i++) put(16'(i), 16'($urandom_range(63, 0)));
            for (int j = 0; j < 3; j++) put(16'($urandom_range(63, 0)), 16'hFFFF);
            t = 16'($urandom_range(60, 0));
            model_run(t, 15);
            max_wait = $urandom_range(3, 0);
            noise_en = 1;
            log_q.delete();
            pulse_start(t);
            wait_run(15, 500, ok);
            chk($sformatf("r%0d_done", r), 32'(ok), 32'd1);
            chk($sformatf("r%0d_count", r), instr_count, 32'(m_cnt));
            chk($sformatf("r%0d_halted", r), 32'(halted), 32'(m_halt));
            chk($sformatf("r%0d_pc", r), 32'(pc), 32'(m_pc));
            areset = 1'b1;
            compare_trace($sformatf("r%0d_trace", r), 6 * m_cnt);
        end

        do_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
